// File: rtl/bp_pkg.sv
// Shared types and constants for the BP path checker.
package bp_pkg;

  localparam int unsigned ROWS     = 64;
  localparam int unsigned COLS     = 8;
  localparam int unsigned MOVES    = ROWS - 1;
  localparam int unsigned POS_W    = 3;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned CELL_W   = 2;
  localparam int unsigned ROW_BITS = COLS * CELL_W;
  localparam int unsigned CODE_W   = 3;

  typedef enum logic [1:0] {
    STAY  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2,
    JUMP  = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    WALL  = 2'd3
  } cell_e;

  localparam logic [CODE_W-1:0] ERR_WALL  = 3'd0;
  localparam logic [CODE_W-1:0] ERR_OOB   = 3'd1;
  localparam logic [CODE_W-1:0] ERR_LOW   = 3'd2;
  localparam logic [CODE_W-1:0] ERR_HIGH  = 3'd3;
  localparam logic [CODE_W-1:0] ERR_DJUMP = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/bp_map_buf.sv
// Obstacle map storage: one 16-bit row per map line, combinational cell read.
module bp_map_buf
  import bp_pkg::*;
(
  input  logic                clk,
  input  logic                i_we,
  input  logic [ROW_W-1:0]    i_waddr,
  input  logic [ROW_BITS-1:0] i_wdata,
  input  logic [ROW_W-1:0]    i_raddr,
  input  logic [POS_W-1:0]    i_rcol,
  output logic [CELL_W-1:0]   o_cell
);

  logic [ROW_BITS-1:0] r_mem [ROWS];

  // Row write during map load.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Cell lookup so one move can be judged per cycle.
  always_comb begin
    o_cell = r_mem[i_raddr][{i_rcol, 1'b0} +: CELL_W];
  end

endmodule

// File: rtl/bp_path_checker.sv
// Replays the BP move stream against the captured obstacle map and reports
// a single verdict. Define BP_CHK_JUMP_RULE_EN to flag back-to-back jumps.
module bp_path_checker
  import bp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [POS_W-1:0]    guy,
  input  logic [CELL_W-1:0]   in0,
  input  logic [CELL_W-1:0]   in1,
  input  logic [CELL_W-1:0]   in2,
  input  logic [CELL_W-1:0]   in3,
  input  logic [CELL_W-1:0]   in4,
  input  logic [CELL_W-1:0]   in5,
  input  logic [CELL_W-1:0]   in6,
  input  logic [CELL_W-1:0]   in7,
  input  logic                mv_valid,
  input  logic [1:0]          mv,
  output logic                done,
  output logic                pass,
  output logic [ROW_W-1:0]    err_step,
  output logic [CODE_W-1:0]   err_code
);

  state_e              r_state;
  logic [POS_W-1:0]    r_pos;
  logic [ROW_W-1:0]    r_row;
  logic                r_full;
  logic [ROW_W-1:0]    r_step;
  logic                r_err;
  logic [ROW_W-1:0]    r_err_step;
  logic [CODE_W-1:0]   r_err_code;
`ifdef BP_CHK_JUMP_RULE_EN
  logic                r_last_jump;
`endif

  logic [ROW_BITS-1:0] w_row_data;
  logic                w_we;
  logic [ROW_W-1:0]    w_waddr;
  logic [ROW_W-1:0]    w_raddr;
  logic [CELL_W-1:0]   w_cell;
  move_e               w_mv;
  logic                w_oob;
  logic [POS_W-1:0]    w_pos_next;
  logic                w_viol;
  logic [CODE_W-1:0]   w_code;
  logic                w_last_move;
  logic                w_fin_err;
  logic [ROW_W-1:0]    w_fin_step;
  logic [CODE_W-1:0]   w_fin_code;

  // Map write port: row 0 on the IDLE->LOAD cycle, then one row per in_valid.
  always_comb begin
    w_row_data = {in7, in6, in5, in4, in3, in2, in1, in0};
    w_we       = 1'b0;
    w_waddr    = '0;
    if (r_state == IDLE && in_valid) begin
      w_we = 1'b1;
    end else if (r_state == LOAD && in_valid && !r_full) begin
      w_we    = 1'b1;
      w_waddr = r_row;
    end
  end

  assign w_raddr = r_step + ROW_W'(1);

  bp_map_buf u_map (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_row_data),
    .i_raddr (w_raddr),
    .i_rcol  (w_pos_next),
    .o_cell  (w_cell)
  );

  // Candidate position; a move off the edge leaves the position unchanged.
  always_comb begin
    w_mv       = move_e'(mv);
    w_oob      = 1'b0;
    w_pos_next = r_pos;
    case (w_mv)
      RIGHT: begin
        if (r_pos == POS_W'(COLS - 1)) w_oob = 1'b1;
        else                           w_pos_next = r_pos + POS_W'(1);
      end
      LEFT: begin
        if (r_pos == '0) w_oob = 1'b1;
        else             w_pos_next = r_pos - POS_W'(1);
      end
      default: ;
    endcase
  end

  // Violation for the current move, highest priority first.
  always_comb begin
    w_viol = 1'b0;
    w_code = ERR_WALL;
    if (w_oob) begin
      w_viol = 1'b1;
      w_code = ERR_OOB;
    end
`ifdef BP_CHK_JUMP_RULE_EN
    else if (w_mv == JUMP && r_last_jump) begin
      w_viol = 1'b1;
      w_code = ERR_DJUMP;
    end
`endif
    else begin
      case (cell_e'(w_cell))
        WALL: begin
          w_viol = 1'b1;
          w_code = ERR_WALL;
        end
        LOW: begin
          if (w_mv != JUMP) begin
            w_viol = 1'b1;
            w_code = ERR_LOW;
          end
        end
        HIGH: begin
          if (w_mv == JUMP) begin
            w_viol = 1'b1;
            w_code = ERR_HIGH;
          end
        end
        default: ;
      endcase
    end
  end

  // Verdict including the final move, which lands in the same edge as the report.
  always_comb begin
    w_last_move = (r_step == ROW_W'(MOVES - 1));
    w_fin_err   = r_err | w_viol;
    w_fin_step  = r_err ? r_err_step : r_step;
    w_fin_code  = r_err ? r_err_code : w_code;
  end

  // Control FSM with registered verdict outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pos       <= '0;
      r_row       <= '0;
      r_full      <= 1'b0;
      r_step      <= '0;
      r_err       <= 1'b0;
      r_err_step  <= '0;
      r_err_code  <= '0;
`ifdef BP_CHK_JUMP_RULE_EN
      r_last_jump <= 1'b0;
`endif
      done        <= 1'b0;
      pass        <= 1'b0;
      err_step    <= '0;
      err_code    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_pos   <= guy;
            r_row   <= ROW_W'(1);
            r_full  <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (!r_full) begin
              if (r_row == ROW_W'(ROWS - 1)) r_full <= 1'b1;
              else                           r_row  <= r_row + ROW_W'(1);
            end
          end else begin
            r_step      <= '0;
            r_err       <= 1'b0;
            r_err_step  <= '0;
            r_err_code  <= '0;
`ifdef BP_CHK_JUMP_RULE_EN
            r_last_jump <= 1'b0;
`endif
            r_state     <= CHECK;
          end
        end
        CHECK: begin
          if (mv_valid) begin
            r_pos  <= w_pos_next;
            r_step <= r_step + ROW_W'(1);
`ifdef BP_CHK_JUMP_RULE_EN
            r_last_jump <= (w_mv == JUMP);
`endif
            if (!r_err && w_viol) begin
              r_err      <= 1'b1;
              r_err_step <= r_step;
              r_err_code <= w_code;
            end
            if (w_last_move) begin
              done     <= 1'b1;
              pass     <= !w_fin_err;
              err_step <= w_fin_err ? w_fin_step : '0;
              err_code <= w_fin_err ? w_fin_code : '0;
              r_state  <= REPORT;
            end
          end
        end
        REPORT: begin
          done     <= 1'b0;
          pass     <= 1'b0;
          err_step <= '0;
          err_code <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_path_checker.sv
// Directed bench for bp_path_checker with a verdict scoreboard.
module tb_bp_path_checker;
  import bp_pkg::*;

  typedef struct packed {
    logic       pass;
    logic [5:0] step;
    logic [2:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] guy;
  logic [1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic       mv_valid;
  logic [1:0] mv;
  logic       done;
  logic       pass;
  logic [5:0] err_step;
  logic [2:0] err_code;

  exp_t       sb[$];
  int         n_vec    = 0;
  int         n_miss   = 0;
  int         done_cnt = 0;
  logic [1:0] tmap [64][8];
  logic [1:0] tmv  [63];

  bp_path_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .guy      (guy),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .in5      (in5),
    .in6      (in6),
    .in7      (in7),
    .mv_valid (mv_valid),
    .mv       (mv),
    .done     (done),
    .pass     (pass),
    .err_step (err_step),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_all();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 8; c++) tmap[r][c] = 2'd0;
    for (int k = 0; k < 63; k++) tmv[k] = STAY;
  endtask

  task automatic load_map(input logic [2:0] g, input bit stray, input int extra);
    for (int r = 0; r < 64 + extra; r++) begin
      @(negedge clk);
      in_valid = 1'b1;
      guy      = g;
      if (r < 64) begin
        in0 = tmap[r][0]; in1 = tmap[r][1]; in2 = tmap[r][2]; in3 = tmap[r][3];
        in4 = tmap[r][4]; in5 = tmap[r][5]; in6 = tmap[r][6]; in7 = tmap[r][7];
      end else begin
        {in7, in6, in5, in4, in3, in2, in1, in0} = '1;
      end
      mv_valid = stray;
      mv       = LEFT;
    end
    @(negedge clk);
    in_valid = 1'b0;
    mv_valid = 1'b0;
  endtask

  task automatic drive_moves(input int first, input int last, input bit gaps);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      mv_valid = 1'b1;
      mv       = tmv[k];
      if (gaps && k < last) begin
        @(negedge clk);
        mv_valid = 1'b0;
      end
    end
  endtask

  task automatic run_pattern(input string tag, input logic [2:0] g, input bit stray,
                             input int extra, input bit gaps, input exp_t e);
    int   dc0;
    exp_t ex;
    dc0 = done_cnt;
    sb.push_back(e);
    load_map(g, stray, extra);
    drive_moves(0, 62, gaps);
    @(negedge clk);
    mv_valid = 1'b0;
    chk({tag, ".done_latency"}, 32'(done), 32'd1);
    ex = sb.pop_front();
    chk({tag, ".pass"},     32'(pass),     32'(ex.pass));
    chk({tag, ".err_step"}, 32'(err_step), 32'(ex.step));
    chk({tag, ".err_code"}, 32'(err_code), 32'(ex.code));
    @(negedge clk);
    chk({tag, ".done_single"}, 32'(done), 32'd0);
    chk({tag, ".done_count"},  32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    rst_n = 1'b0; in_valid = 1'b0; mv_valid = 1'b0; mv = 2'd0; guy = 3'd0;
    {in7, in6, in5, in4, in3, in2, in1, in0} = '0;
    repeat (3) @(negedge clk);
    chk("reset.done",     32'(done),     32'd0);
    chk("reset.pass",     32'(pass),     32'd0);
    chk("reset.err_step", 32'(err_step), 32'd0);
    chk("reset.err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    clear_all();
    run_pattern("all_empty", 3'd3, 1'b0, 0, 1'b0, {1'b1, 6'd0, 3'd0});

    clear_all();
    for (int c = 0; c < 8; c++) tmap[5][c] = WALL;
    tmap[5][3] = LOW;
    tmv[4] = JUMP;
    run_pattern("low_jumped", 3'd3, 1'b0, 0, 1'b0, {1'b1, 6'd0, 3'd0});
    tmv[4] = STAY;
    run_pattern("low_walked", 3'd3, 1'b0, 0, 1'b0, {1'b0, 6'd4, 3'd2});

    clear_all();
    tmv[0] = RIGHT;
    tmap[11][7] = WALL;
    run_pattern("oob_first", 3'd7, 1'b0, 0, 1'b0, {1'b0, 6'd0, 3'd1});

    clear_all();
    for (int c = 0; c < 8; c++) tmap[20][c] = WALL;
    tmap[20][2] = HIGH;
    tmv[19] = JUMP;
    run_pattern("high_jumped", 3'd2, 1'b0, 0, 1'b0, {1'b0, 6'd19, 3'd3});

    clear_all();
    run_pattern("gaps_stray", 3'd0, 1'b1, 0, 1'b1, {1'b1, 6'd0, 3'd0});

    clear_all();
    dc0 = done_cnt;
    load_map(3'd3, 1'b0, 0);
    drive_moves(0, 29, 1'b0);
    @(negedge clk);
    mv_valid = 1'b1;
    mv       = STAY;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    mv_valid = 1'b0;
    chk("abort.done",     32'(done),     32'd0);
    chk("abort.pass",     32'(pass),     32'd0);
    chk("abort.err_step", 32'(err_step), 32'd0);
    chk("abort.err_code", 32'(err_code), 32'd0);
    drive_moves(31, 62, 1'b0);
    @(negedge clk);
    mv_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.no_done", 32'(done_cnt - dc0), 32'd0);

    clear_all();
    for (int k = 0; k < 63; k++) tmv[k] = (k % 2 == 0) ? RIGHT : LEFT;
    run_pattern("after_abort_extra_rows", 3'd4, 1'b0, 2, 1'b0, {1'b1, 6'd0, 3'd0});

    clear_all();
    tmv[7] = JUMP;
    tmv[8] = JUMP;
`ifdef BP_CHK_JUMP_RULE_EN
    run_pattern("double_jump", 3'd5, 1'b0, 0, 1'b0, {1'b0, 6'd8, 3'd4});
`else
    run_pattern("double_jump", 3'd5, 1'b0, 0, 1'b0, {1'b1, 6'd0, 3'd0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
